// File: rtl/sr_tap_bank.sv
// Multi-channel tapped sample history with per-channel circular buffers.
// Supports single-tap random reads and a newest-to-oldest tap sweep for the MAC engine.
module sr_tap_bank #(
    parameter int IN_WIDTH = 24,
    parameter int DEPTH    = 8,
    parameter int NUM_CH   = 2,
    parameter int TAP_W    = $clog2(DEPTH) + 1,
    parameter int CH_W     = (NUM_CH > 1 ? $clog2(NUM_CH) : 1)
) (
    input  logic                ic_clk,
    input  logic                ic_rst,
    input  logic                ic_push,
    input  logic [CH_W-1:0]     ic_push_ch,
    input  logic [IN_WIDTH-1:0] id_data_in,
    output logic                oc_push_rdy,
    input  logic                ic_rd,
    input  logic                ic_sweep,
    input  logic [CH_W-1:0]     ic_ch,
    input  logic [TAP_W-1:0]    ic_tap,
    output logic [IN_WIDTH-1:0] od_data_out,
    output logic                oc_valid,
    output logic                oc_last,
    output logic [TAP_W-1:0]    od_tap,
    output logic                oc_busy
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic {
        IDLE,
        SWEEP
    } state_t;

    state_t state;

    logic [IN_WIDTH-1:0] mem    [NUM_CH][DEPTH];
    logic [PTR_W-1:0]    wr_ptr [NUM_CH];
    logic [TAP_W-1:0]    fill   [NUM_CH];

    logic [CH_W-1:0]  sw_ch;
    logic [PTR_W-1:0] sw_ptr;
    logic [TAP_W-1:0] sw_fill;
    logic [TAP_W-1:0] sw_cnt;

    logic ch_ok;
    logic push_ch_ok;
    logic push_acc;
    logic sweep_start;
    logic read_go;

    logic [CH_W-1:0]     lk_ch;
    logic [TAP_W-1:0]    lk_tap;
    logic [PTR_W-1:0]    lk_ptr;
    logic [TAP_W-1:0]    lk_fill;
    logic                lk_ok;
    logic [PTR_W-1:0]    lk_idx;
    logic [IN_WIDTH-1:0] lk_val;

    assign ch_ok       = int'(ic_ch) < NUM_CH;
    assign push_ch_ok  = int'(ic_push_ch) < NUM_CH;
    assign sweep_start = (state == IDLE) && ic_sweep && ch_ok;
    assign read_go     = (state == IDLE) && ic_rd && !ic_sweep;

    // The swept channel is frozen so the snapshot pointer stays valid for all taps.
    assign oc_push_rdy = !((oc_busy && (ic_push_ch == sw_ch)) ||
                           ((state == IDLE) && ic_sweep && ch_ok && (ic_ch == ic_push_ch)));
    assign push_acc    = ic_push && oc_push_rdy && push_ch_ok;

    // One shared lookup port: sweep taps while sweeping, otherwise the request channel.
    always_comb begin
        lk_ch   = ic_ch;
        lk_tap  = ic_tap;
        lk_ptr  = '0;
        lk_fill = '0;
        lk_ok   = ch_ok;
        if (state == SWEEP) begin
            lk_ch   = sw_ch;
            lk_tap  = sw_cnt;
            lk_ptr  = sw_ptr;
            lk_fill = sw_fill;
            lk_ok   = 1'b1;
        end else begin
            if (ic_sweep) begin
                lk_tap = '0;
            end
            if (ch_ok) begin
                lk_ptr  = wr_ptr[ic_ch];
                lk_fill = fill[ic_ch];
            end
        end

        lk_idx = '0;
        lk_val = '0;
        if (lk_ok && (int'(lk_tap) < DEPTH) && (lk_tap < lk_fill)) begin
            lk_idx = PTR_W'((int'(lk_ptr) + DEPTH - 1 - int'(lk_tap)) % DEPTH);
            lk_val = mem[lk_ch][lk_idx];
        end
    end

    always_ff @(posedge ic_clk) begin
        if (!ic_rst && push_acc) begin
            mem[ic_push_ch][wr_ptr[ic_push_ch]] <= id_data_in;
        end
    end

    always_ff @(posedge ic_clk) begin
        if (ic_rst) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                wr_ptr[c] <= '0;
                fill[c]   <= '0;
            end
        end else if (push_acc) begin
            if (wr_ptr[ic_push_ch] == PTR_W'(DEPTH - 1)) begin
                wr_ptr[ic_push_ch] <= '0;
            end else begin
                wr_ptr[ic_push_ch] <= wr_ptr[ic_push_ch] + 1'b1;
            end
            if (int'(fill[ic_push_ch]) < DEPTH) begin
                fill[ic_push_ch] <= fill[ic_push_ch] + 1'b1;
            end
        end
    end

    always_ff @(posedge ic_clk) begin
        if (ic_rst) begin
            state       <= IDLE;
            od_data_out <= '0;
            oc_valid    <= 1'b0;
            oc_last     <= 1'b0;
            od_tap      <= '0;
            oc_busy     <= 1'b0;
            sw_ch       <= '0;
            sw_ptr      <= '0;
            sw_fill     <= '0;
            sw_cnt      <= '0;
        end else begin
            oc_valid <= 1'b0;
            oc_last  <= 1'b0;
            case (state)
                IDLE: begin
                    oc_busy <= 1'b0;
                    if (sweep_start) begin
                        sw_ch       <= ic_ch;
                        sw_ptr      <= wr_ptr[ic_ch];
                        sw_fill     <= fill[ic_ch];
                        sw_cnt      <= TAP_W'(1);
                        oc_valid    <= 1'b1;
                        od_tap      <= '0;
                        od_data_out <= lk_val;
                        oc_busy     <= 1'b1;
                        state       <= SWEEP;
                    end else if (read_go) begin
                        oc_valid    <= 1'b1;
                        od_tap      <= ic_tap;
                        od_data_out <= lk_val;
                    end
                end
                SWEEP: begin
                    oc_valid    <= 1'b1;
                    od_tap      <= sw_cnt;
                    od_data_out <= lk_val;
                    sw_cnt      <= sw_cnt + 1'b1;
                    if (sw_cnt == TAP_W'(DEPTH - 1)) begin
                        oc_last <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sr_tap_bank.sv
// Bench for sr_tap_bank: directed scenarios plus random traffic against a
// push-log reference model (taps found by scanning the log of accepted pushes).
module tb_sr_tap_bank;

    localparam int IW    = 24;
    localparam int DEPTH = 8;
    localparam int NC    = 2;
    localparam int TAP_W = $clog2(DEPTH) + 1;
    localparam int CH_W  = (NC > 1 ? $clog2(NC) : 1);

    logic             clk = 1'b0;
    logic             ic_rst = 1'b1;
    logic             ic_push = 1'b0;
    logic [CH_W-1:0]  ic_push_ch = '0;
    logic [IW-1:0]    id_data_in = '0;
    logic             oc_push_rdy;
    logic             ic_rd = 1'b0;
    logic             ic_sweep = 1'b0;
    logic [CH_W-1:0]  ic_ch = '0;
    logic [TAP_W-1:0] ic_tap = '0;
    logic [IW-1:0]    od_data_out;
    logic             oc_valid;
    logic             oc_last;
    logic [TAP_W-1:0] od_tap;
    logic             oc_busy;

    always #5 clk = ~clk;

    sr_tap_bank #(
        .IN_WIDTH(IW),
        .DEPTH   (DEPTH),
        .NUM_CH  (NC)
    ) dut (
        .ic_clk     (clk),
        .ic_rst     (ic_rst),
        .ic_push    (ic_push),
        .ic_push_ch (ic_push_ch),
        .id_data_in (id_data_in),
        .oc_push_rdy(oc_push_rdy),
        .ic_rd      (ic_rd),
        .ic_sweep   (ic_sweep),
        .ic_ch      (ic_ch),
        .ic_tap     (ic_tap),
        .od_data_out(od_data_out),
        .oc_valid   (oc_valid),
        .oc_last    (oc_last),
        .od_tap     (od_tap),
        .oc_busy    (oc_busy)
    );

    typedef struct {
        int          ch;
        logic [IW-1:0] d;
    } ent_t;

    ent_t          plog[$];
    logic [IW-1:0] swq[$];
    int            swch = 0;
    logic          exp_valid = 1'b0;
    logic          exp_last = 1'b0;
    logic          exp_busy = 1'b0;
    logic [IW-1:0] exp_data = '0;
    logic [TAP_W-1:0] exp_tap = '0;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Tap k of a channel = k-th most recent accepted push to it since reset.
    function automatic logic [IW-1:0] tapv(input int ch, input int k);
        int seen = 0;
        if (k >= DEPTH) return '0;
        for (int i = plog.size() - 1; i >= 0; i--) begin
            if (plog[i].ch == ch) begin
                if (seen == k) return plog[i].d;
                seen++;
            end
        end
        return '0;
    endfunction

    task automatic cyc(input logic rst, input logic push, input logic [CH_W-1:0] pch,
                       input logic [IW-1:0] d, input logic rd, input logic sw,
                       input logic [CH_W-1:0] ch, input logic [TAP_W-1:0] tap);
        logic erdy;
        ent_t e;
        ic_rst = rst; ic_push = push; ic_push_ch = pch; id_data_in = d;
        ic_rd = rd; ic_sweep = sw; ic_ch = ch; ic_tap = tap;
        #1;
        erdy = !((exp_busy && int'(pch) == swch) ||
                 (swq.size() == 0 && sw && int'(ch) < NC && ch == pch));
        if (!rst) chk("push_rdy", oc_push_rdy, erdy);
        @(posedge clk);
        if (rst) begin
            plog.delete(); swq.delete();
            exp_valid = 0; exp_last = 0; exp_busy = 0; exp_data = '0; exp_tap = '0;
        end else begin
            exp_valid = 0; exp_last = 0;
            if (swq.size() > 0) begin
                exp_valid = 1;
                exp_tap   = TAP_W'(DEPTH - swq.size());
                exp_data  = swq.pop_front();
                exp_last  = (swq.size() == 0);
                exp_busy  = 1;
            end else if (sw && int'(ch) < NC) begin
                swch = int'(ch);
                for (int k = 1; k < DEPTH; k++) swq.push_back(tapv(swch, k));
                exp_valid = 1; exp_tap = '0; exp_data = tapv(swch, 0); exp_busy = 1;
            end else begin
                exp_busy = 0;
                if (rd) begin
                    exp_valid = 1;
                    exp_tap   = tap;
                    exp_data  = (int'(ch) < NC) ? tapv(int'(ch), int'(tap)) : '0;
                end
            end
            if (push && erdy && int'(pch) < NC) begin
                e.ch = int'(pch); e.d = d;
                plog.push_back(e);
            end
        end
        #1;
        chk("valid", oc_valid, exp_valid);
        chk("last", oc_last, exp_last);
        chk("busy", oc_busy, exp_busy);
        chk("data", od_data_out, exp_data);
        chk("tap", od_tap, exp_tap);
    endtask

    task automatic idle();
        cyc(0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    task automatic push(input int ch, input int d);
        cyc(0, 1, CH_W'(ch), IW'(d), 0, 0, '0, '0);
    endtask

    task automatic rdt(input int ch, input int tap);
        cyc(0, 0, '0, '0, 1, 0, CH_W'(ch), TAP_W'(tap));
    endtask

    initial begin
        logic rd, sw, rst;
        cyc(1, 0, '0, '0, 0, 0, '0, '0);
        cyc(1, 0, '0, '0, 0, 0, '0, '0);
        chk("rst_valid", oc_valid, 0);
        chk("rst_busy", oc_busy, 0);

        rdt(0, 0);
        chk("empty_tap0", od_data_out, 0);

        push(0, 1); push(0, 2); push(0, 3);
        for (int t = 0; t < 4; t++) rdt(0, t);
        chk("fill_mask_tap3", od_data_out, 0);
        rdt(0, 0);
        chk("ch0_tap0", od_data_out, 3);
        rdt(1, 0);

        for (int i = 1; i <= 10; i++) push(1, i);
        cyc(0, 0, '0, '0, 0, 1, 1, '0);
        chk("sweep_d0", od_data_out, 10);
        for (int i = 1; i < DEPTH; i++) begin
            idle();
            chk("sweep_d", od_data_out, 32'(10 - i));
            chk("sweep_last", oc_last, (i == DEPTH - 1));
        end
        idle();
        chk("sweep_busy_end", oc_busy, 0);

        cyc(0, 1, 0, 77, 0, 1, 0, '0);
        chk("rdy_start_same_ch", oc_push_rdy, 0);
        cyc(0, 1, 0, 88, 1, 1, 0, 2);
        cyc(0, 1, 1, 55, 1, 0, 1, 0);
        for (int i = 0; i < 5; i++) idle();
        idle();
        rdt(0, 0);
        chk("no_store_in_sweep", od_data_out, 3);
        rdt(1, 0);
        chk("ch1_push_in_sweep", od_data_out, 55);

        cyc(0, 1, 0, 5, 1, 0, 0, 0);
        chk("rd_before_wr", od_data_out, 3);
        rdt(0, 0);
        chk("rd_after_wr", od_data_out, 5);
        rdt(0, DEPTH);
        chk("tap_oob", od_data_out, 0);

        cyc(0, 0, '0, '0, 0, 1, 1, '0);
        idle(); idle(); idle();
        cyc(1, 0, '0, '0, 0, 0, '0, '0);
        chk("rst_mid_valid", oc_valid, 0);
        chk("rst_mid_busy", oc_busy, 0);
        for (int c = 0; c < NC; c++)
            for (int t = 0; t < DEPTH; t++) begin
                rdt(c, t);
                chk("post_rst_zero", od_data_out, 0);
            end

        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            rd  = ($urandom_range(0, 9) < 3);
            sw  = ($urandom_range(0, 9) == 0);
            // Keep requests off the final sweep output cycle.
            if (exp_busy && swq.size() == 0) begin
                rd = 0; sw = 0;
            end
            cyc(rst, ($urandom_range(0, 1) == 1), CH_W'($urandom_range(0, NC - 1)),
                IW'($urandom), rd, sw, CH_W'($urandom_range(0, NC - 1)),
                TAP_W'($urandom_range(0, DEPTH + 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
